// File: rtl/fx_pkg.sv
// Shared types and helpers for the front-panel effect sequencer.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package fx_pkg;

  // Commit FSM: waiting for a change, waiting for a frame boundary, holding a fresh commit.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HOLD = 2'd2
  } fx_state_e;

  // Index 0 means no effect enabled.
  localparam logic [2:0] FX_BYPASS = 3'd0;

  // Largest effect count a 3-bit index can address.
  localparam int FX_MAX_N = 7;

  // Index 1..7 selects enable bit idx-1; bypass yields all zeros.
  function automatic logic [FX_MAX_N-1:0] idx_to_onehot(input logic [2:0] idx);
    logic [FX_MAX_N-1:0] oh;
    oh = '0;
    if (idx != FX_BYPASS) begin
      oh[idx - 3'd1] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter, press-edge pulse.
// Latency: raw edge to press_pulse is 2 + DEB_CYCLES clk cycles.
// Backpressure: none; the key is sampled every cycle and releases produce no event.
module key_debounce #(
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             level_pressed;

  // Synchroniser resets to the released (high) level so reset release is not seen as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], key_n};
    end
  end

  assign level_pressed = ~sync[1];

  // Accept a new level only after it has held for DEB_CYCLES cycles; pulse on press only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      pressed     <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      if (level_pressed != pressed) begin
        if (cnt == CNT_LAST) begin
          cnt         <= '0;
          pressed     <= level_pressed;
          press_pulse <= level_pressed;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/fx_mode_sequencer.sv
// Front-panel effect selector: debounced keys pick a requested effect, committed on frame starts.
// Latency: fx_en/fx_idx update one cycle after the committing frame_en; key press adds 2+DEB_CYCLES.
// Backpressure: lock defers commits; a fresh commit is held for at least one full frame.
module fx_mode_sequencer
  import fx_pkg::*;
#(
  parameter int N_FX       = 4,
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            key_next_n,
  input  logic            key_clr_n,
  input  logic            frame_en,
  input  logic            lock,
  output logic [N_FX-1:0] fx_en,
  output logic [2:0]      fx_idx,
  output logic [2:0]      req_idx,
  output logic            pending
);

  localparam logic [2:0] FX_LAST = 3'(N_FX);

  logic            next_pulse;
  logic            clr_pulse;
  logic            next_held;
  logic            clr_held;
  logic            unused_held;
  fx_state_e       state;
  fx_state_e       state_next;
  logic            commit;
  logic [2:0]      req_next;
  logic [2:0]      fx_idx_next;
  logic [N_FX-1:0] fx_en_next;

  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_deb_next (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_n       (key_next_n),
    .pressed     (next_held),
    .press_pulse (next_pulse)
  );

  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_deb_clr (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_n       (key_clr_n),
    .pressed     (clr_held),
    .press_pulse (clr_pulse)
  );

  // Held key levels are not consumed here; only press events matter.
  assign unused_held = next_held ^ clr_held;

  // Requested index: clear wins over next; next wraps from the last effect back to bypass.
  always_comb begin
    req_next = req_idx;
    if (clr_pulse) begin
      req_next = FX_BYPASS;
    end else if (next_pulse) begin
      req_next = (req_idx == FX_LAST) ? FX_BYPASS : req_idx + 3'd1;
    end
  end

  // Request register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_idx <= FX_BYPASS;
    end else begin
      req_idx <= req_next;
    end
  end

  // Commit FSM: a request only reaches the enables on an unlocked frame start, then holds a frame.
  always_comb begin
    state_next = state;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (req_idx != fx_idx) begin
          state_next = PEND;
        end
      end
      PEND: begin
        if (req_idx == fx_idx) begin
          state_next = IDLE;
        end else if (frame_en && !lock) begin
          commit     = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (frame_en) begin
          state_next = (req_idx != fx_idx) ? PEND : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next committed index and enables; the request value sampled at the frame start is the one shown.
  always_comb begin
    fx_idx_next = fx_idx;
    fx_en_next  = fx_en;
    if (commit) begin
      fx_idx_next = req_idx;
      fx_en_next  = N_FX'(idx_to_onehot(req_idx));
    end
  end

  // Output registers; pending is computed from next values so it always matches the index outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fx_idx  <= FX_BYPASS;
      fx_en   <= '0;
      pending <= 1'b0;
    end else begin
      fx_idx  <= fx_idx_next;
      fx_en   <= fx_en_next;
      pending <= (req_next != fx_idx_next);
    end
  end

endmodule

// File: tb/tb_fx_mode_sequencer.sv
// Directed and randomized bench for the effect sequencer against a press/frame-level model.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_fx_mode_sequencer;

  localparam int N_FX  = 4;
  localparam int DEB   = 4;
  localparam int CNT_W = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            key_next_n = 1'b1;
  logic            key_clr_n = 1'b1;
  logic            frame_en = 1'b0;
  logic            lock = 1'b0;
  logic [N_FX-1:0] fx_en;
  logic [2:0]      fx_idx;
  logic [2:0]      req_idx;
  logic            pending;

  int checks = 0;
  int errors = 0;

  // Model: requested index, committed index, and whether the last frame start made a commit.
  int m_req = 0;
  int m_fx = 0;
  bit m_hold = 1'b0;

  int wrap_seq [5] = '{1, 2, 3, 4, 0};

  always #5 clk = ~clk;

  fx_mode_sequencer #(
    .N_FX       (N_FX),
    .DEB_CYCLES (DEB),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_next_n (key_next_n),
    .key_clr_n  (key_clr_n),
    .frame_en   (frame_en),
    .lock       (lock),
    .fx_en      (fx_en),
    .fx_idx     (fx_idx),
    .req_idx    (req_idx),
    .pending    (pending)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int onehot(input int idx);
    return (idx == 0) ? 0 : (1 << (idx - 1));
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".req"},     8'(req_idx), 8'(m_req));
    check({tag, ".fx_idx"},  8'(fx_idx),  8'(m_fx));
    check({tag, ".fx_en"},   8'(fx_en),   8'(onehot(m_fx)));
    check({tag, ".pending"}, 8'(pending), 8'(m_req != m_fx));
    check({tag, ".onehot"},  8'($countones(fx_en) <= 1), 8'd1);
    check({tag, ".range"},   8'(fx_idx <= 3'(N_FX)), 8'd1);
  endtask

  task automatic m_reset();
    m_req  = 0;
    m_fx   = 0;
    m_hold = 1'b0;
  endtask

  task automatic m_press(input bit nxt, input bit clr);
    if (clr) m_req = 0;
    else if (nxt) m_req = (m_req == N_FX) ? 0 : m_req + 1;
  endtask

  // A frame start right after a commit only ends the hold; otherwise an unlocked difference commits.
  task automatic m_frame();
    if (m_hold) begin
      m_hold = 1'b0;
    end else if (!lock && m_req != m_fx) begin
      m_fx   = m_req;
      m_hold = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the selected keys low for len cycles, then release and let the release settle.
  task automatic press(input bit nxt, input bit clr, input int len);
    key_next_n = !nxt;
    key_clr_n  = !clr;
    repeat (len) tick();
    key_next_n = 1'b1;
    key_clr_n  = 1'b1;
    repeat (DEB + 6) tick();
    if (len >= DEB) m_press(nxt, clr);
  endtask

  task automatic frame();
    frame_en = 1'b1;
    tick();
    frame_en = 1'b0;
    m_frame();
    tick();
  endtask

  task automatic frame2();
    frame_en = 1'b1;
    tick();
    m_frame();
    tick();
    m_frame();
    frame_en = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    // Reset values, observed while reset is still asserted.
    #1 rst_n = 1'b0;
    m_reset();
    #1 check_all("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // A 3-cycle glitch is rejected.
    press(1'b1, 1'b0, 3);
    check_all("glitch");

    // A 10-cycle press: the press event lands 6 cycles after the edge, the request one cycle later.
    key_next_n = 1'b0;
    repeat (6) tick();
    check("latency.before", 8'(req_idx), 8'd0);
    tick();
    check("latency.after", 8'(req_idx), 8'd1);
    repeat (3) tick();
    key_next_n = 1'b1;
    repeat (DEB + 6) tick();
    m_press(1'b1, 1'b0);
    check_all("press1");

    // First commit on a frame start.
    frame();
    check_all("commit1");
    check("commit1.en", 8'(fx_en), 8'h01);

    // Three presses inside the hold frame; exit frame does not commit, the next one does.
    press(1'b1, 1'b0, 6);
    press(1'b1, 1'b0, 6);
    press(1'b1, 1'b0, 6);
    check_all("hold.req");
    frame();
    check_all("hold.exit");
    frame();
    check_all("hold.commit");
    check("hold.en", 8'(fx_en), 8'h08);
    frame();
    check_all("hold.idle");

    // Clear, then five presses walk through the wrap.
    press(1'b0, 1'b1, 6);
    check_all("clr");
    for (int i = 0; i < 5; i++) begin
      press(1'b1, 1'b0, 5);
      check("wrap.seq", 8'(req_idx), 8'(wrap_seq[i]));
      check_all("wrap");
    end
    press(1'b1, 1'b0, 6);
    press(1'b1, 1'b0, 6);
    press(1'b1, 1'b0, 6);
    check("both.pre", 8'(req_idx), 8'd3);
    press(1'b1, 1'b1, 6);
    check("both.req", 8'(req_idx), 8'd0);
    check_all("both");

    // Press event and frame start in the same cycle: the old request is committed.
    key_next_n = 1'b0;
    repeat (6) tick();
    frame_en = 1'b1;
    tick();
    frame_en = 1'b0;
    m_frame();
    m_press(1'b1, 1'b0);
    repeat (3) tick();
    key_next_n = 1'b1;
    repeat (DEB + 6) tick();
    check_all("same_cycle");
    frame();
    check_all("same_cycle.exit");
    frame();
    check_all("same_cycle.commit");

    // Lock defers commits across frames.
    press(1'b1, 1'b0, 6);
    frame();
    check_all("lock.exit");
    lock = 1'b1;
    frame();
    frame();
    check_all("lock.held");
    lock = 1'b0;
    frame();
    check_all("unlock");
    check("unlock.en", 8'(fx_en), 8'h02);

    // Asynchronous reset in the middle of a hold frame.
    #2 rst_n = 1'b0;
    #1 m_reset();
    check_all("async_reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Back-to-back frame starts are independent.
    press(1'b1, 1'b0, 6);
    frame2();
    check_all("frame2.commit_exit");
    press(1'b1, 1'b0, 6);
    frame();
    check_all("frame2.commit");
    press(1'b1, 1'b0, 6);
    frame2();
    check_all("frame2.exit_commit");

    // Randomized mix of presses, glitches, clears, locks and frame starts.
    for (int i = 0; i < 60; i++) begin
      lock = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0, 1:    press(1'b1, 1'b0, int'($urandom_range(1, 8)));
        2:       press(1'b0, 1'b1, int'($urandom_range(1, 8)));
        3:       press(1'b1, 1'b1, int'($urandom_range(4, 8)));
        4:       frame();
        default: frame2();
      endcase
      check_all("rand");
    end
    lock = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fx_mode_sequencer.md
Name: fx_mode_sequencer

Overview:
- Front-panel controller for the pixel-effect datapath (grayscale and sibling effects).
- Debounces two KEY pushbuttons and keeps a requested effect index.
- Commits the request to the effect-enable lines only on a frame boundary, so no frame is ever rendered with mixed effects.
- Sits between the KEY pins / D8M frame timing and the `enable` inputs of the effect blocks.

Parameters:
- N_FX, 4, number of effect blocks driven; index 0 is bypass, indices 1..N_FX select effect fx_en[idx-1].
- DEB_CYCLES, 500000, number of clk cycles a raw key level must be stable to be accepted (use 4 in simulation).
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
- clk, input, 1, pixel clock.
- rst_n, input, 1, asynchronous active-low reset.
- key_next_n, input, 1, raw pushbutton, active-low; a press advances the requested effect.
- key_clr_n, input, 1, raw pushbutton, active-low; a press requests bypass (index 0).
- frame_en, input, 1, one-cycle pulse at frame start.
- lock, input, 1, while high, commits are deferred.
- fx_en, output, N_FX, one-hot effect enables, or all zero for bypass.
- fx_idx, output, 3, currently committed index.
- req_idx, output, 3, currently requested index.
- pending, output, 1, high while req_idx != fx_idx.

Behaviour:
- Reset (async assert, sync release):
  - fx_en=0, fx_idx=0, req_idx=0, pending=0.
  - FSM=IDLE; debounce counters=0; debounced key states=released.
- Debounce, per key:
  - Synchronise the raw input with a 2-flop synchroniser.
  - If the synced level differs from the debounced state, count up; otherwise clear the counter.
  - When the count reaches DEB_CYCLES-1, flip the debounced state and clear the counter.
  - A press event is a 1-cycle pulse on the released->pressed flip only. A release generates no event.
  - Latency from raw edge to press pulse: 2 + DEB_CYCLES cycles.
- Request register, updated every cycle:
  - clr press: req_idx <= 0. This has priority when it coincides with a next press.
  - next press: req_idx <= (req_idx == N_FX) ? 0 : req_idx+1, i.e. wrap to bypass.
- FSM states IDLE, PEND, HOLD:
  - IDLE: go to PEND when req_idx != fx_idx, evaluated on registered values.
  - PEND: on frame_en && !lock, commit:
    - fx_idx <= req_idx;
    - fx_en <= one-hot of req_idx, or 0 when req_idx = 0;
    - go to HOLD.
  - PEND with frame_en && lock: stay in PEND, no commit.
  - PEND when the request returns to equal fx_idx before any commit: go to IDLE, no commit.
  - HOLD: guarantees each committed mode is shown for at least one full frame. On the next frame_en, go to PEND if req_idx != fx_idx, otherwise to IDLE. Never commits.
- Outputs:
  - fx_en and fx_idx change only in the cycle after a frame_en pulse (1-cycle registered latency).
  - pending = (req_idx != fx_idx), registered.
- Boundary conditions:
  - Press pulse and frame_en in the same cycle while in PEND: commit the old req_idx. The new req_idx takes effect no earlier than the frame after HOLD.
  - frame_en asserted on two consecutive cycles: treat each cycle independently; the second pulse is the HOLD exit.
  - Reset asserted mid-PEND or mid-HOLD: all state is lost and outputs go to 0 immediately (asynchronous).
  - At most one bit of fx_en is high at any time.
  - fx_idx is never greater than N_FX.

Decomposition:
- Shared package fx_pkg:
  - FSM state encoding (IDLE=2'd0, PEND=2'd1, HOLD=2'd2);
  - FX_BYPASS=3'd0;
  - function idx_to_onehot.
- One sub-module, key_debounce (params DEB_CYCLES, CNT_W; ports clk, rst_n, key_n, pressed, press_pulse), instantiated twice.

Test Plan (DEB_CYCLES=4, N_FX=4):
- Reset: assert rst_n=0 mid-frame with fx_idx=2 -> fx_en=0, fx_idx=0, pending=0 the same cycle, without waiting for a clock edge.
- Debounce: a 3-cycle low glitch on key_next_n gives no press and req_idx stays 0. A 10-cycle low gives exactly one press 6 cycles after the edge: req_idx=1, pending=1, fx_en unchanged until frame_en.
- Frame commit: req_idx=1 in PEND, pulse frame_en -> next cycle fx_en=4'b0001, fx_idx=1, pending=0.
- HOLD: three next presses land in the HOLD frame, giving req_idx=4. The HOLD-exit frame_en produces no commit. The following frame_en gives fx_en=4'b1000.
- Wrap and clear:
  - five next presses from 0 -> req_idx sequence 1, 2, 3, 4, 0;
  - simultaneous clr and next presses at req_idx=3 -> req_idx=0.
- Lock: lock=1 with req_idx=2 pending -> two frame_en pulses with no change. Drop lock; the next frame_en gives fx_en=4'b0010.
